pb_debounce_ctrl: RTL and testbench
===================================

Name: pb_debounce_ctrl

Overview:
- Multi-channel push-button conditioner that sits directly upstream of the single-pulse stage.
- Per channel, it synchronises the raw pad input and filters contact bounce with a counter-based state machine.
- It drives a clean level `pb_debounced` to the single-pulse stage.
- It also generates long-press and auto-repeat strobes for menu/value-scroll logic.

Parameters:
- N_BTN, 4, number of independent button channels.
- DB_CYCLES, 16, consecutive stable samples required to accept a level change; must be >= 2.
- LONG_CYCLES, 1000, cycles held in PRESSED before the `long_press` strobe; must be >= 2.
- REPEAT_CYCLES, 200, period of `repeat_pulse` after `long_press`; must be >= 2.

Ports:
- clock, input, 1, system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pb_raw, input, N_BTN, raw button pins (active-high, asynchronous, bouncing).
- pb_debounced, output, N_BTN, filtered level per channel; feeds the single-pulse stage.
- long_press, output, N_BTN, one-cycle strobe when the hold reaches LONG_CYCLES.
- repeat_pulse, output, N_BTN, one-cycle strobe every REPEAT_CYCLES after `long_press` while held.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Sync flops, all counters and all outputs go to 0.
  - Every channel FSM goes to RELEASED.
  - Outputs stay 0 until the first clock edge after reset deassertion.
- Synchroniser: 2-flop chain per channel, `s1<=pb_raw`, `s2<=s1`. Only `s2` feeds the FSM.
- Per-channel FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - `db_cnt` width is `$clog2(DB_CYCLES)+1`.
  - `hold_cnt` and `rep_cnt` are sized from LONG_CYCLES and REPEAT_CYCLES.
- RELEASED:
  - `s2=1` -> PRESS_CHK, `db_cnt=1`.
  - Otherwise stay.
- PRESS_CHK:
  - `s2=0` -> RELEASED, `db_cnt=0` (bounce rejected).
  - `db_cnt==DB_CYCLES-1` -> PRESSED, `pb_debounced=1`, `hold_cnt=0`, `rep_cnt=0`, long-press-fired flag cleared.
  - Otherwise `db_cnt+1`.
- PRESSED (`pb_debounced=1`):
  - `s2=0` -> RELEASE_CHK, `db_cnt=1`, hold/repeat counters frozen.
  - Before long press: `hold_cnt` increments. When `hold_cnt==LONG_CYCLES-1`, assert `long_press` for 1 cycle, set fired flag, `rep_cnt=0`. `hold_cnt` then stops (no wrap).
  - After fired flag: `rep_cnt` increments. When `rep_cnt==REPEAT_CYCLES-1`, assert `repeat_pulse` for 1 cycle and set `rep_cnt=0`.
- RELEASE_CHK (`pb_debounced` stays 1; no strobes):
  - `s2=1` -> PRESSED; counters resume from their frozen values.
  - `db_cnt==DB_CYCLES-1` -> RELEASED, `pb_debounced=0`, all counters and the fired flag cleared.
  - Otherwise `db_cnt+1`.
- Timing (all outputs registered):
  - Press acceptance: `pb_debounced` rises after edge DB_CYCLES+2, counting edge 1 as the first edge with `pb_raw` stable high. Release is symmetric.
  - If PRESSED is entered at edge E with no release glitches, `long_press` is high in the cycle after edge E+LONG_CYCLES.
  - `repeat_pulse` is high after edges E+LONG_CYCLES+m*REPEAT_CYCLES, m>=1.
- Simultaneous events:
  - If `s2` falls in the same cycle a strobe would fire, the release transition wins and no strobe is emitted.
  - `long_press` and `repeat_pulse` are never high in the same cycle on one channel.
- Channels are fully independent; any combination may be active in the same cycle.
- Reset mid-hold: everything clears immediately. After release of reset with the button still held, a full DB_CYCLES acceptance runs again, followed by a fresh LONG_CYCLES count.

Test Plan (bench params: N_BTN=2, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5):
- Clean press on ch0 at edge 1, held -> `pb_debounced[0]` rises after edge 6; ch1 outputs stay 0.
- Bounce on ch0: high 3 cycles / low 1 / high 2 / low 1, repeated 5x -> `pb_debounced[0]` stays 0; a final stable high rises it 6 edges later.
- Long hold of ch0 for 60 cycles after acceptance at edge E -> `long_press[0]` pulses after E+20; `repeat_pulse[0]` pulses after E+25, E+30 and every 5 edges while held; each pulse is exactly 1 cycle wide.
- Release glitch: in PRESSED at hold_cnt=10, `pb_raw` low for 2 cycles -> `pb_debounced` stays 1; `long_press` is delayed by the 2 frozen cycles plus synchroniser alignment. A sustained low clears `pb_debounced` after 4 stable samples, with no strobes.
- Reset asserted mid-repeat (asynchronous, between edges) -> all outputs 0 immediately. After deassert with the button held, `pb_debounced` re-rises after 6 edges and `long_press` 20 edges later.
- Both channels pressed simultaneously, ch1 released at hold 12 -> ch0 strobes unaffected; ch1 emits no `long_press`.

Source files
------------

// File: rtl/pb_debounce_ctrl.sv
// Multi-channel push-button conditioner: two-flop synchroniser, counter-based
// debounce FSM, and long-press / auto-repeat strobe generation per channel.
module pb_debounce_ctrl #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 200
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] pb_debounced,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DB_W   = $clog2(DB_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_RELEASE_CHK
  } state_e;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pb_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    state_e              state_q, state_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic                fired_q, fired_d;
    logic                deb_q, deb_d;
    logic                long_q, long_d;
    logic                rpt_q, rpt_d;
    logic                s2;

    assign s2 = s2_q[gi];

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_RELEASED;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        fired_q    <= 1'b0;
        deb_q      <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        fired_q    <= fired_d;
        deb_q      <= deb_d;
        long_q     <= long_d;
        rpt_q      <= rpt_d;
      end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      fired_d    = fired_q;
      deb_d      = deb_q;
      long_d     = 1'b0;
      rpt_d      = 1'b0;

      unique case (state_q)
        ST_RELEASED: begin
          if (s2) begin
            state_d  = ST_PRESS_CHK;
            db_cnt_d = DB_W'(1);
          end
        end

        ST_PRESS_CHK: begin
          if (!s2) begin
            state_d  = ST_RELEASED;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d    = ST_PRESSED;
            deb_d      = 1'b1;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            fired_d    = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end

        ST_PRESSED: begin
          // A falling sample takes priority over any strobe due this cycle.
          if (!s2) begin
            state_d  = ST_RELEASE_CHK;
            db_cnt_d = DB_W'(1);
          end else if (!fired_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
              long_d    = 1'b1;
              fired_d   = 1'b1;
              rep_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end else begin
            if (rep_cnt_q == REP_LAST) begin
              rpt_d     = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
          end
        end

        ST_RELEASE_CHK: begin
          // Hold/repeat counters stay frozen here so a short glitch only pauses them.
          if (s2) begin
            state_d  = ST_PRESSED;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d    = ST_RELEASED;
            deb_d      = 1'b0;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            fired_d    = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end

        default: begin
          state_d = ST_RELEASED;
        end
      endcase
    end

    assign pb_debounced[gi] = deb_q;
    assign long_press[gi]   = long_q;
    assign repeat_pulse[gi] = rpt_q;
  end

endmodule

// File: tb/tb_pb_debounce_ctrl.sv
// Self-checking bench for pb_debounce_ctrl: directed scenarios plus random
// bouncing stimulus, all checked every cycle against a sample-counting model.
module tb_pb_debounce_ctrl;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [N-1:0] pb_raw;
  logic [N-1:0] pb_debounced;
  logic [N-1:0] long_press;
  logic [N-1:0] repeat_pulse;

  always #5 clock = ~clock;

  pb_debounce_ctrl #(
    .N_BTN         (N),
    .DB_CYCLES     (DB),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .pb_raw       (pb_raw),
    .pb_debounced (pb_debounced),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_no, got, exp);
    end
  endtask

  // Reference model: the level flips once DB consecutive synchronised samples
  // disagree with it; a "held" edge is one where the current and previous
  // samples are both high while the level is high. Long press fires on the
  // LONG-th held edge, repeats on every REP-th held edge after that.
  int m_s1[N], m_s2[N], m_prev[N], m_level[N], m_run[N], m_held[N];
  int m_long[N], m_rpt[N];

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_s1[ch] = 0; m_s2[ch] = 0; m_prev[ch] = 0; m_level[ch] = 0;
      m_run[ch] = 0; m_held[ch] = 0; m_long[ch] = 0; m_rpt[ch] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    for (int ch = 0; ch < N; ch++) begin
      int samp;
      samp = m_s2[ch];
      m_long[ch] = 0;
      m_rpt[ch]  = 0;
      if (samp != m_level[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DB) begin
          m_level[ch] = samp;
          m_run[ch]   = 0;
          m_held[ch]  = 0;
        end
      end else begin
        m_run[ch] = 0;
        if (m_level[ch] == 1 && m_prev[ch] == 1) begin
          m_held[ch]++;
          if (m_held[ch] == LONG) m_long[ch] = 1;
          else if (m_held[ch] > LONG && (m_held[ch] - LONG) % REP == 0) m_rpt[ch] = 1;
        end
      end
      m_prev[ch] = samp;
      m_s2[ch]   = m_s1[ch];
      m_s1[ch]   = int'(raw[ch]);
    end
  endtask

  // Observation trackers for channel 0 (and long-press count on channel 1).
  int t_rise, t_fall, t_long, t_rpt1, t_rpt2, t_rpt_n, t_long1_n, t_deb_hi;
  logic t_prev_deb;

  task automatic clear_track();
    edge_no   = 0;
    t_rise    = -1; t_fall = -1; t_long = -1; t_rpt1 = -1; t_rpt2 = -1;
    t_rpt_n   = 0;  t_long1_n = 0; t_deb_hi = 0;
    t_prev_deb = pb_debounced[0];
  endtask

  task automatic run_cycle(input logic [N-1:0] raw);
    pb_raw = raw;
    @(posedge clock);
    edge_no++;
    model_edge(raw);
    #1;
    for (int ch = 0; ch < N; ch++) begin
      check($sformatf("deb[%0d]", ch),  32'(pb_debounced[ch]), 32'(m_level[ch]));
      check($sformatf("long[%0d]", ch), 32'(long_press[ch]),   32'(m_long[ch]));
      check($sformatf("rpt[%0d]", ch),  32'(repeat_pulse[ch]), 32'(m_rpt[ch]));
    end
    if (pb_debounced[0] && !t_prev_deb && t_rise < 0) t_rise = edge_no;
    if (!pb_debounced[0] && t_prev_deb && t_fall < 0) t_fall = edge_no;
    t_prev_deb = pb_debounced[0];
    if (long_press[0] && t_long < 0) t_long = edge_no;
    if (repeat_pulse[0]) begin
      t_rpt_n++;
      if (t_rpt_n == 1) t_rpt1 = edge_no;
      if (t_rpt_n == 2) t_rpt2 = edge_no;
    end
    if (long_press[1]) t_long1_n++;
    if (pb_debounced[0]) t_deb_hi++;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_cycle_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_deb",  32'(pb_debounced), 32'd0);
    check("rst_long", 32'(long_press),   32'd0);
    check("rst_rpt",  32'(repeat_pulse), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  int   bounce_pat[7] = '{1, 1, 1, 0, 1, 1, 0};
  int   seg_left[N];
  logic [N-1:0] cur;

  initial begin
    rst_n  = 1'b0;
    pb_raw = '0;
    model_reset();
    @(posedge clock);
    #1;
    check("reset_deb",  32'(pb_debounced), 32'd0);
    check("reset_long", 32'(long_press),   32'd0);
    check("reset_rpt",  32'(repeat_pulse), 32'd0);
    #2 rst_n = 1'b1;

    // Clean press and long hold on ch0.
    clear_track();
    repeat (70) run_cycle(2'b01);
    check("press_latency", t_rise, DB + 2);
    check("long_at",       t_long, DB + 2 + LONG);
    check("rpt1_at",       t_rpt1, DB + 2 + LONG + REP);
    check("rpt2_at",       t_rpt2, DB + 2 + LONG + 2 * REP);
    check("rpt_count",     t_rpt_n, (70 - (DB + 2 + LONG)) / REP);
    check("ch1_no_long",   t_long1_n, 0);
    clear_track();
    repeat (10) run_cycle(2'b00);
    check("release_latency", t_fall, DB + 2);

    // Bounce rejection, then a stable press.
    clear_track();
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 7; i++) run_cycle({1'b0, 1'(bounce_pat[i])});
    check("bounce_reject", t_deb_hi, 0);
    clear_track();
    repeat (10) run_cycle(2'b01);
    check("bounce_accept", t_rise, DB + 2);
    repeat (10) run_cycle(2'b00);

    // Release glitch at hold count 10, then a release landing on a repeat slot.
    clear_track();
    repeat (DB + 2 + 10) run_cycle(2'b01);
    repeat (2) run_cycle(2'b00);
    repeat (18) run_cycle(2'b01);
    check("glitch_keeps_deb", t_fall, -1);
    check("glitch_long_at",   t_long, DB + 2 + LONG + 3);
    clear_track();
    repeat (12) run_cycle(2'b00);
    check("glitch_release_latency", t_fall, DB + 2);
    check("release_no_long", t_long, -1);
    check("release_no_rpt",  t_rpt_n, 0);

    // Reset mid-repeat with the button still held.
    clear_track();
    repeat (33) run_cycle(2'b01);
    check("pre_reset_rpt", t_rpt1, DB + 2 + LONG + REP);
    mid_cycle_reset();
    clear_track();
    repeat (30) run_cycle(2'b01);
    check("post_reset_rise", t_rise, DB + 2);
    check("post_reset_long", t_long, DB + 2 + LONG);
    repeat (12) run_cycle(2'b00);

    // Both channels pressed; ch1 released at hold 12.
    clear_track();
    repeat (DB + 2 + 12) run_cycle(2'b11);
    repeat (40) run_cycle(2'b01);
    check("dual_ch0_long", t_long, DB + 2 + LONG);
    check("dual_ch0_rpt1", t_rpt1, DB + 2 + LONG + REP);
    check("dual_ch1_long", t_long1_n, 0);
    repeat (12) run_cycle(2'b00);

    // Random bouncing and long holds on both channels.
    cur = '0;
    for (int ch = 0; ch < N; ch++) seg_left[ch] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (seg_left[ch] == 0) begin
          cur[ch] = 1'($urandom_range(0, 1));
          seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                     : int'($urandom_range(1, 6));
        end
        seg_left[ch]--;
      end
      run_cycle(cur);
      if (c == 450) mid_cycle_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
